// File: rtl/alu_puf_pkg.sv
// rtl/alu_puf_pkg.sv - shared widths and sequencer state type for the ALU PUF controller
// Purpose: common localparams and the state enum used by alu_puf_ctrl and puf_vote_acc.
package alu_puf_pkg;

  localparam int CHAL_W = 128;
  localparam int OP_W   = 16;
  localparam int RESP_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SETUP,
    FIRE,
    CAPT,
    VOTE,
    DONE
  } state_t;

endpackage

// File: rtl/puf_vote_acc.sv
// rtl/puf_vote_acc.sv - per-bit ones counters with majority vote and stability flags
// Purpose: accumulates synchronized PUF response bits over N_EVAL evaluations.
// Ports:
//   clk, reset      clock and synchronous active-low reset
//   clr             zero all counters (new request)
//   inc_en          add the current bits into the counters (capture cycle)
//   bits            synchronized response bits
//   vote            majority result per bit (ties resolve to 0)
//   stable          1 where every sample agreed (count is 0 or N_EVAL)
module puf_vote_acc
  import alu_puf_pkg::*;
#(
  parameter int N_EVAL = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc_en,
  input  logic [RESP_W-1:0] bits,
  output logic [RESP_W-1:0] vote,
  output logic [RESP_W-1:0] stable
);

  // Wide enough to hold N_EVAL itself, so the counters never wrap.
  localparam int CW = $clog2(N_EVAL + 1);

  logic [CW-1:0] cnt [RESP_W];

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      for (int i = 0; i < RESP_W; i++) cnt[i] <= '0;
    end else if (inc_en) begin
      for (int i = 0; i < RESP_W; i++) cnt[i] <= cnt[i] + CW'(bits[i]);
    end
  end

  // With an even N_EVAL a tie (cnt == N_EVAL/2) fails the strict compare,
  // so it votes 0, and it is never 0 or N_EVAL, so it is flagged unstable.
  always_comb begin
    vote   = '0;
    stable = '0;
    for (int i = 0; i < RESP_W; i++) begin
      vote[i]   = (cnt[i] > CW'(N_EVAL / 2));
      stable[i] = (cnt[i] == '0) || (cnt[i] == CW'(N_EVAL));
    end
  end

endmodule

// File: rtl/alu_puf_ctrl.sv
// rtl/alu_puf_ctrl.sv - evaluation sequencer and majority voter for the 16-bit ALU PUF
// Purpose: accepts one request, fires the PUF N_EVAL times and returns a voted response.
// Ports:
//   clk, reset                    clock and synchronous active-low reset
//   start, challenge, op_a, op_b  request (sampled in IDLE only)
//   busy                          high outside IDLE
//   puf_challenge, puf_a, puf_b   latched request driven to the PUF
//   puf_trigger, puf_reset        registered PUF control pins
//   puf_response                  asynchronous arbiter outputs
//   resp, resp_stable, resp_valid result, held until resp_ready
//   resp_ready                    consumer acceptance
module alu_puf_ctrl
  import alu_puf_pkg::*;
#(
  parameter int N_EVAL    = 7,
  parameter int RST_CYC   = 4,
  parameter int SETUP_CYC = 8,
  parameter int EVAL_CYC  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CHAL_W-1:0] challenge,
  input  logic [OP_W-1:0]   op_a,
  input  logic [OP_W-1:0]   op_b,
  output logic              busy,
  output logic [CHAL_W-1:0] puf_challenge,
  output logic [OP_W-1:0]   puf_a,
  output logic [OP_W-1:0]   puf_b,
  output logic              puf_trigger,
  output logic              puf_reset,
  input  logic [RESP_W-1:0] puf_response,
  output logic [RESP_W-1:0] resp,
  output logic [RESP_W-1:0] resp_stable,
  output logic              resp_valid,
  input  logic              resp_ready
);

  localparam int MAXC = (RST_CYC > SETUP_CYC) ?
                        ((RST_CYC > EVAL_CYC) ? RST_CYC : EVAL_CYC) :
                        ((SETUP_CYC > EVAL_CYC) ? SETUP_CYC : EVAL_CYC);
  localparam int PH_W = $clog2(MAXC + 1);
  localparam int EI_W = (N_EVAL > 1) ? $clog2(N_EVAL) : 1;

  state_t            state, next_state;
  logic [PH_W-1:0]   phase;
  logic [EI_W-1:0]   eval_idx;
  logic [RESP_W-1:0] sync1, sync2;
  logic              acc_clr, acc_inc, last_eval;
  logic [RESP_W-1:0] vote, stable;

  assign busy = (state != IDLE);

  always_comb begin
    next_state = state;
    acc_clr    = 1'b0;
    acc_inc    = 1'b0;
    last_eval  = (eval_idx == EI_W'(N_EVAL - 1));
    case (state)
      IDLE:  if (start) begin
               next_state = CLR;
               acc_clr    = 1'b1;
             end
      CLR:   if (phase == PH_W'(RST_CYC - 1))   next_state = SETUP;
      SETUP: if (phase == PH_W'(SETUP_CYC - 1)) next_state = FIRE;
      FIRE:  if (phase == PH_W'(EVAL_CYC - 1))  next_state = CAPT;
      CAPT:  begin
               acc_inc    = 1'b1;
               next_state = last_eval ? VOTE : CLR;
             end
      VOTE:  next_state = DONE;
      DONE:  if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      phase         <= '0;
      eval_idx      <= '0;
      sync1         <= '0;
      sync2         <= '0;
      puf_challenge <= '0;
      puf_a         <= '0;
      puf_b         <= '0;
      puf_trigger   <= 1'b0;
      puf_reset     <= 1'b0;
      resp          <= '0;
      resp_stable   <= '0;
      resp_valid    <= 1'b0;
    end else begin
      state <= next_state;
      sync1 <= puf_response;
      sync2 <= sync1;
      // Phase counts cycles spent in the current state; restarts on every transition.
      phase <= (next_state != state) ? '0 : phase + PH_W'(1);
      if (state == IDLE && start) begin
        puf_challenge <= challenge;
        puf_a         <= op_a;
        puf_b         <= op_b;
        eval_idx      <= '0;
      end
      if (state == CAPT && !last_eval) eval_idx <= eval_idx + EI_W'(1);
      // Pins are registered copies of the state being entered, so they line up with it.
      puf_reset   <= (next_state == CLR);
      puf_trigger <= (next_state == FIRE) || (next_state == CAPT);
      resp_valid  <= (next_state == DONE);
      if (state == VOTE) begin
        resp        <= vote;
        resp_stable <= stable;
      end
    end
  end

  puf_vote_acc #(.N_EVAL(N_EVAL)) u_acc (
    .clk    (clk),
    .reset  (reset),
    .clr    (acc_clr),
    .inc_en (acc_inc),
    .bits   (sync2),
    .vote   (vote),
    .stable (stable)
  );

endmodule
